// File: rtl/bus_arb_pkg.sv
// Shared types and mux-select encodings for the two-master bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_M0   = 2'd1;
    localparam logic [1:0] SEL_M1   = 2'd2;

endpackage

// File: rtl/bus_arb_timeout.sv
// Grant-hold counter: cleared on grant entry, counts while enabled, saturates at the limit.
module bus_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && (count != LAST))
            count <= count + CNT_W'(1);
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin bus arbiter with forced release after TIMEOUT_CYCLES.
module bus_arbiter_2m
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_0,
    input  logic       req_1,
    input  logic       done,
    output logic       grant_0,
    output logic       grant_1,
    output logic [1:0] sel,
    output logic       bus_busy,
    output logic       timeout
);

    state_t state, next;
    logic   last_m1;     // 1 when master 1 held the most recent grant
    logic   tmo_set, tmo_pend;
    logic   clr, en, expired;

    bus_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (en),
        .expired (expired)
    );

    always_comb begin
        next    = state;
        tmo_set = 1'b0;
        case (state)
            IDLE: begin
                if (req_0 && req_1) next = last_m1 ? GNT0 : GNT1;
                else if (req_0)     next = GNT0;
                else if (req_1)     next = GNT1;
            end
            GNT0: begin
                if (done || !req_0 || expired) next = GAP;
                tmo_set = expired && !done;
            end
            GNT1: begin
                if (done || !req_1 || expired) next = GAP;
                tmo_set = expired && !done;
            end
            GAP:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign clr = (state == IDLE) && (next != IDLE);
    assign en  = (state == GNT0) || (state == GNT1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_m1  <= 1'b1;
            tmo_pend <= 1'b0;
        end else begin
            state    <= next;
            tmo_pend <= tmo_set;
            if (clr) last_m1 <= (next == GNT1);
        end
    end

    // Output stage decodes the registered state, so grants trail the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_0  <= 1'b0;
            grant_1  <= 1'b0;
            sel      <= SEL_NONE;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            grant_0  <= (state == GNT0);
            grant_1  <= (state == GNT1);
            sel      <= (state == GNT0) ? SEL_M0 : (state == GNT1) ? SEL_M1 : SEL_NONE;
            bus_busy <= (state == GNT0) || (state == GNT1);
            timeout  <= tmo_pend;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed vector bench for bus_arbiter_2m: table walk plus timeout and reset sequences.
module tb_bus_arbiter_2m;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_0 = 1'b0, req_1 = 1'b0, done = 1'b0;
    logic       grant_0, grant_1, bus_busy, timeout;
    logic [1:0] sel;

    int errors = 0;
    int checks = 0;

    // Expected output word: {grant_0, grant_1, sel, bus_busy, timeout}
    localparam logic [5:0] Z   = 6'b000000;
    localparam logic [5:0] G0  = 6'b100110;
    localparam logic [5:0] G1  = 6'b011010;
    localparam logic [5:0] TMO = 6'b000001;

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic       d;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [20];

    bus_arbiter_2m #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_0    (req_0),
        .req_1    (req_1),
        .done     (done),
        .grant_0  (grant_0),
        .grant_1  (grant_1),
        .sel      (sel),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {grant_0, grant_1, sel, bus_busy, timeout};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got g0g1_sel_busy_tmo=%b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic d);
        req_0 = r0;
        req_1 = r1;
        done  = d;
    endtask

    // Continuous invariants on the outputs while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((grant_0 && grant_1) ||
                (sel !== (grant_0 ? 2'd1 : grant_1 ? 2'd2 : 2'd0)) ||
                (bus_busy !== (grant_0 | grant_1))) begin
                errors++;
                $display("FAIL invariant: g0=%b g1=%b sel=%0d busy=%b", grant_0, grant_1, sel, bus_busy);
            end
        end
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, Z};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, Z};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, G0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, G0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, G0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, Z};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, Z};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, Z};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, G1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, G1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, Z};
        vecs[11] = '{1'b1, 1'b1, 1'b0, Z};
        vecs[12] = '{1'b1, 1'b1, 1'b0, G0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, G0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, Z};
        vecs[15] = '{1'b1, 1'b1, 1'b0, Z};
        vecs[16] = '{1'b1, 1'b1, 1'b0, G1};
        vecs[17] = '{1'b1, 1'b0, 1'b0, G1};
        vecs[18] = '{1'b1, 1'b0, 1'b1, Z};
        vecs[19] = '{1'b0, 1'b0, 1'b1, Z};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset", Z);
        @(negedge clk);
        rst_n = 1'b1;

        // Single grant, round robin, owner drop, done ignored outside grants
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].r0, vecs[i].r1, vecs[i].d);
            step();
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Forced release after 16 grant cycles
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk("tmo_entry", Z);
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("tmo_hold%0d", i), G1);
        end
        step();
        chk("tmo_pulse", TMO);
        drive(1'b0, 1'b0, 1'b0);
        step();
        chk("tmo_after", Z);

        // done coinciding with the final count wins over timeout
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk("race_entry", Z);
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("race_hold%0d", i), G1);
        end
        drive(1'b0, 1'b1, 1'b1);
        step();
        chk("race_done", G1);
        drive(1'b0, 1'b0, 1'b0);
        step();
        chk("race_gap", Z);
        step();
        chk("race_idle", Z);

        // Async reset mid-grant, then a tie goes to master 0
        drive(1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("pre_rst_g0", G0);
        rst_n = 1'b0;
        #1;
        chk("async_rst", Z);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        step();
        chk("tie_entry", Z);
        step();
        chk("tie_m0", G0);
        drive(1'b0, 1'b0, 1'b1);
        step();
        step();
        chk("final_idle", Z);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2m.md
BUS_ARBITER_2M -- requirements
Module: bus_arbiter_2m

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of cycles a grant may be held without done before forced release; legal range 2..255.
REQ-002 Parameter CNT_W, default 8, is the width of the timeout counter and SHALL satisfy 2**CNT_W > TIMEOUT_CYCLES.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  Reset; asynchronous assertion, active-low.
REQ-005 req_0  input  1  Bus request from master 0; held high until the transfer completes.
REQ-006 req_1  input  1  Bus request from master 1; same rules as req_0.
REQ-007 done  input  1  Single-cycle pulse from the addressed slave marking transfer complete.
REQ-008 grant_0  output  1  Master 0 owns the bus.
REQ-009 grant_1  output  1  Master 1 owns the bus.
REQ-010 sel  output  2  Write-data/address mux select: 2'd1 = master 0, 2'd2 = master 1, 2'd0 = no owner.
REQ-011 bus_busy  output  1  High while either grant is high.
REQ-012 timeout  output  1  One-cycle pulse when a grant is forcibly revoked.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 FSM states: IDLE, GNT0, GNT1, GAP.
REQ-015 IDLE: only req_0 -> GNT0; only req_1 -> GNT1; neither -> stay IDLE.
REQ-016 IDLE with req_0 and req_1 both high -> grant the master not recorded in last_grant (round-robin).
REQ-017 last_grant SHALL update on every entry to GNT0 or GNT1.
REQ-018 Grant latency: a request sampled high in IDLE at edge n SHALL produce grant_x = 1 and sel set after edge n+1.
REQ-019 GNT0/GNT1 exit -> GAP on the first of three events: done = 1, owning req deasserted, or timeout.
REQ-020 GAP SHALL last exactly one cycle with grants 0 and sel 2'd0, then go to IDLE; back-to-back ownership therefore costs at least 2 idle cycles.
REQ-021 done SHALL be ignored in IDLE and GAP.
REQ-022 The timeout counter SHALL clear on entry to GNT0/GNT1 and increment once per cycle while in a GNT state.
REQ-023 When count = TIMEOUT_CYCLES-1 and done = 0, the block SHALL pulse timeout for one cycle coincident with the GAP cycle.
REQ-024 When done and the timeout condition occur in the same cycle, done SHALL win and timeout SHALL stay 0.
REQ-025 The counter SHALL saturate and never wrap while in a GNT state.
REQ-026 grant_0 and grant_1 SHALL never be high simultaneously; sel SHALL always agree with the grants.
REQ-027 bus_busy SHALL equal grant_0 OR grant_1.

Reset
REQ-028 On rst_n low: state IDLE; grant_0, grant_1, bus_busy and timeout = 0; sel = 2'd0; counter = 0; last_grant = master 1, so master 0 wins the first tie.
REQ-029 Reset asserted mid-grant SHALL drop the grants immediately (asynchronous); release is synchronous to clk.

Structure
REQ-030 Shared package bus_arb_pkg SHALL hold the state enum and the three sel encoding constants (SEL_NONE, SEL_M0, SEL_M1) for reuse by the mux-side logic.
REQ-031 The timeout counter SHALL be the sub-module bus_arb_timeout, with ports clk, rst_n, clr, en and expired.

Verification
REQ-032 req_0 high in IDLE, done after 3 cycles -> grant_0 = 1 and sel = 1 one cycle later; after done, one GAP cycle, then IDLE.
REQ-033 req_0 and req_1 held high continuously, done after every grant -> grants alternate 0,1,0,1, with master 0 first after reset.
REQ-034 req_1 held with no done and TIMEOUT_CYCLES = 16 -> grant_1 high for 16 cycles, then timeout pulses once and grant_1 = 0.
REQ-035 done and the timeout condition coincide at count 15 -> timeout stays 0 and normal release occurs.
REQ-036 rst_n pulsed low while in GNT0 -> grant_0 drops without waiting for a clk edge, sel = 0, and the next tie grants master 0.
REQ-037 Continuous assertion check -> grant_0 AND grant_1 never both 1, and sel always consistent with the grants.
